// File: rtl/bus_narrow16.sv
// bus_narrow16: splits 32-bit register accesses into big-endian 16-bit
// narrow-bus halves, high half first, with a per-half timeout.
module bus_narrow16 #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wr,
  input  logic        req,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] naddr,
  output logic [15:0] nwdata,
  output logic [1:0]  nwstrb,
  output logic        nwr,
  output logic        nreq,
  input  logic [15:0] nrdata,
  input  logic        nack,
  input  logic        nerr
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HI   = 3'd1;
  localparam logic [2:0] S_LO   = 3'd2;
  localparam logic [2:0] S_NOP  = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [29:0]   a_q, a_d;
  logic [31:0]   wd_q, wd_d;
  logic [3:0]    ws_q, ws_d;
  logic          wr_q, wr_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          nreq_q, nreq_d;
  logic [31:0]   naddr_q, naddr_d;
  logic [15:0]   nwdata_q, nwdata_d;
  logic [1:0]    nwstrb_q, nwstrb_d;
  logic          nwr_q, nwr_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;

  logic busy, expired, ok, bad;
  logic hi_in, lo_in, lo_q;
  logic unused_abits;

  assign unused_abits = ^addr[1:0];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    wd_d     = wd_q;
    ws_d     = ws_q;
    wr_d     = wr_q;
    tmr_d    = tmr_q;
    nreq_d   = 1'b0;
    naddr_d  = naddr_q;
    nwdata_d = nwdata_q;
    nwstrb_d = nwstrb_q;
    nwr_d    = nwr_q;
    ack_d    = 1'b0;
    err_d    = err_q;
    rdata_d  = rdata_q;

    busy    = (state_q == S_HI) || (state_q == S_LO);
    expired = busy && !nreq_q && !nack && (tmr_q == '0);
    ok      = busy && nack && !nerr;
    bad     = busy && ((nack && nerr) || expired);
    hi_in   = !wr || (wstrb[3:2] != 2'b00);
    lo_in   = !wr || (wstrb[1:0] != 2'b00);
    lo_q    = !wr_q || (ws_q[1:0] != 2'b00);

    // timer counts waiting cycles after each nreq
    if (nreq_q) begin
      tmr_d = TMR_LOAD;
    end else if (busy && tmr_q != '0) begin
      tmr_d = tmr_q - 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          a_d   = addr[31:2];
          wd_d  = wdata;
          ws_d  = wstrb;
          wr_d  = wr;
          err_d = 1'b0;
          nwr_d = wr;
          if (!wr) rdata_d = '0;
          if (hi_in) begin
            nreq_d   = 1'b1;
            naddr_d  = {addr[31:2], 2'b00};
            nwdata_d = wdata[31:16];
            nwstrb_d = wr ? wstrb[3:2] : 2'b11;
            state_d  = S_HI;
          end else if (lo_in) begin
            nreq_d   = 1'b1;
            naddr_d  = {addr[31:2], 2'b10};
            nwdata_d = wdata[15:0];
            nwstrb_d = wstrb[1:0];
            state_d  = S_LO;
          end else begin
            state_d = S_NOP;
          end
        end
      end
      S_HI: begin
        if (bad) begin
          err_d   = 1'b1;
          ack_d   = 1'b1;
          state_d = S_RESP;
        end else if (ok) begin
          if (!wr_q) rdata_d[31:16] = nrdata;
          if (lo_q) begin
            nreq_d   = 1'b1;
            naddr_d  = {a_q, 2'b10};
            nwdata_d = wd_q[15:0];
            nwstrb_d = wr_q ? ws_q[1:0] : 2'b11;
            state_d  = S_LO;
          end else begin
            ack_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_LO: begin
        if (bad) begin
          err_d   = 1'b1;
          ack_d   = 1'b1;
          state_d = S_RESP;
        end else if (ok) begin
          if (!wr_q) rdata_d[15:0] = nrdata;
          ack_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_NOP: begin
        ack_d   = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      wd_q     <= '0;
      ws_q     <= '0;
      wr_q     <= 1'b0;
      tmr_q    <= '0;
      nreq_q   <= 1'b0;
      naddr_q  <= '0;
      nwdata_q <= '0;
      nwstrb_q <= '0;
      nwr_q    <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      wd_q     <= wd_d;
      ws_q     <= ws_d;
      wr_q     <= wr_d;
      tmr_q    <= tmr_d;
      nreq_q   <= nreq_d;
      naddr_q  <= naddr_d;
      nwdata_q <= nwdata_d;
      nwstrb_q <= nwstrb_d;
      nwr_q    <= nwr_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign ack    = ack_q;
  assign err    = err_q;
  assign rdata  = rdata_q;
  assign naddr  = naddr_q;
  assign nwdata = nwdata_q;
  assign nwstrb = nwstrb_q;
  assign nwr    = nwr_q;
  assign nreq   = nreq_q;

endmodule

// File: tb/tb_bus_narrow16.sv
// tb_bus_narrow16: directed vectors against bus_narrow16 (TIMEOUT = 8)
// with a scripted narrow-bus peripheral.
module tb_bus_narrow16;

  logic        clk;
  logic        rstn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wr;
  logic        req;
  logic        ack;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] naddr;
  logic [15:0] nwdata;
  logic [1:0]  nwstrb;
  logic        nwr;
  logic        nreq;
  logic [15:0] nrdata;
  logic        nack;
  logic        nerr;

  bus_narrow16 #(.TIMEOUT(8)) dut (
    .clk(clk), .rstn(rstn),
    .addr(addr), .wdata(wdata), .wstrb(wstrb), .wr(wr), .req(req),
    .ack(ack), .err(err), .rdata(rdata),
    .naddr(naddr), .nwdata(nwdata), .nwstrb(nwstrb), .nwr(nwr),
    .nreq(nreq), .nrdata(nrdata), .nack(nack), .nerr(nerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // peripheral script and log, indexed by narrow access number
  logic [15:0] rsp_d [0:1];
  logic        rsp_e [0:1];
  int          rsp_w [0:1];
  logic        rsp_x [0:1];
  logic [31:0] lg_addr [0:1];
  logic [15:0] lg_wd [0:1];
  logic [1:0]  lg_st [0:1];
  logic        lg_wr [0:1];
  int          lg_cyc [0:1];
  int          ncnt = 0;
  logic        inj = 1'b0;

  initial begin
    nack = 1'b0;
    nerr = 1'b0;
    nrdata = '0;
    forever begin
      @(posedge clk);
      #1;
      nack = inj;
      nerr = 1'b0;
      inj = 1'b0;
      if (nreq) begin
        if (ncnt < 2) begin
          lg_addr[ncnt] = naddr;
          lg_wd[ncnt]   = nwdata;
          lg_st[ncnt]   = nwstrb;
          lg_wr[ncnt]   = nwr;
          lg_cyc[ncnt]  = cyc;
          if (!rsp_x[ncnt]) begin
            int w;
            logic [15:0] d;
            logic e;
            w = rsp_w[ncnt];
            d = rsp_d[ncnt];
            e = rsp_e[ncnt];
            ncnt++;
            repeat (w + 1) @(posedge clk);
            #1;
            nack = 1'b1;
            nerr = e;
            nrdata = d;
          end else begin
            ncnt++;
          end
        end else begin
          ncnt++;
        end
      end
    end
  end

  int   ack_cnt = 0;
  int   ack_cyc = 0;
  logic ack_err;
  logic [31:0] ack_rd;
  int   both_cnt = 0;

  always @(negedge clk) begin
    if (ack) begin
      ack_cnt++;
      ack_cyc = cyc;
      ack_err = err;
      ack_rd  = rdata;
    end
    if (ack && nreq) both_cnt++;
  end

  int req_cyc = 0;

  task automatic set_rsp(input int i, input logic [15:0] d,
                         input logic e, input int w, input logic x);
    rsp_d[i] = d;
    rsp_e[i] = e;
    rsp_w[i] = w;
    rsp_x[i] = x;
  endtask

  task automatic do_req(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic w);
    int start;
    ncnt  = 0;
    start = ack_cnt;
    addr  = a;
    wdata = d;
    wstrb = s;
    wr    = w;
    req   = 1'b1;
    req_cyc = cyc;
    @(posedge clk);
    #1;
    req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ack_cnt != start) break;
      @(posedge clk);
      #1;
    end
    chk("ack_seen", 32'(ack_cnt - start), 32'd1);
  endtask

  task automatic poke_nack(input string tag);
    int start;
    start = ack_cnt;
    @(negedge clk);
    inj = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk(tag, 32'(ack_cnt - start), 32'd0);
  endtask

  initial begin
    int start;
    rstn  = 1'b0;
    addr  = '0;
    wdata = '0;
    wstrb = '0;
    wr    = 1'b0;
    req   = 1'b0;
    set_rsp(0, 16'h0, 1'b0, 0, 1'b0);
    set_rsp(1, 16'h0, 1'b0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_nreq", 32'(nreq), 32'd0);
    chk("rst_nwr", 32'(nwr), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_naddr", naddr, 32'h0);
    chk("rst_nwdata", 32'(nwdata), 32'h0);
    chk("rst_nwstrb", 32'(nwstrb), 32'h0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // read, one wait cycle per half
    set_rsp(0, 16'hDEAD, 1'b0, 1, 1'b0);
    set_rsp(1, 16'hBEEF, 1'b0, 1, 1'b0);
    do_req(32'h1000, 32'h0, 4'h0, 1'b0);
    chk("rd_ncnt", 32'(ncnt), 32'd2);
    chk("rd_addr0", lg_addr[0], 32'h1000);
    chk("rd_addr1", lg_addr[1], 32'h1002);
    chk("rd_st0", 32'(lg_st[0]), 32'h3);
    chk("rd_st1", 32'(lg_st[1]), 32'h3);
    chk("rd_nwr", 32'(lg_wr[0]), 32'd0);
    chk("rd_nreq_lat", 32'(lg_cyc[0] - req_cyc), 32'd1);
    chk("rd_data", ack_rd, 32'hDEADBEEF);
    chk("rd_err", 32'(ack_err), 32'd0);
    chk("rd_lat", 32'(ack_cyc - req_cyc), 32'd7);

    // read, zero wait
    set_rsp(0, 16'h1111, 1'b0, 0, 1'b0);
    set_rsp(1, 16'h2222, 1'b0, 0, 1'b0);
    do_req(32'h3003, 32'h0, 4'h0, 1'b0);
    chk("rd0_addr0", lg_addr[0], 32'h3000);
    chk("rd0_data", ack_rd, 32'h11112222);
    chk("rd0_lat", 32'(ack_cyc - req_cyc), 32'd5);

    // low-half write
    do_req(32'h2004, 32'h12345678, 4'b0011, 1'b1);
    chk("wlo_ncnt", 32'(ncnt), 32'd1);
    chk("wlo_addr", lg_addr[0], 32'h2006);
    chk("wlo_wd", 32'(lg_wd[0]), 32'h5678);
    chk("wlo_st", 32'(lg_st[0]), 32'h3);
    chk("wlo_nwr", 32'(lg_wr[0]), 32'd1);
    chk("wlo_err", 32'(ack_err), 32'd0);
    chk("wlo_lat", 32'(ack_cyc - req_cyc), 32'd3);
    chk("wlo_rdhold", ack_rd, 32'h11112222);

    // single-byte high write
    do_req(32'h10, 32'hCAFE1234, 4'b1000, 1'b1);
    chk("whi_ncnt", 32'(ncnt), 32'd1);
    chk("whi_addr", lg_addr[0], 32'h10);
    chk("whi_st", 32'(lg_st[0]), 32'h2);
    chk("whi_wd", 32'(lg_wd[0]), 32'hCAFE);

    // empty write
    do_req(32'h20, 32'hFFFFFFFF, 4'b0000, 1'b1);
    chk("w0_ncnt", 32'(ncnt), 32'd0);
    chk("w0_lat", 32'(ack_cyc - req_cyc), 32'd2);
    chk("w0_err", 32'(ack_err), 32'd0);

    // high half error
    set_rsp(0, 16'h7777, 1'b1, 0, 1'b0);
    set_rsp(1, 16'h8888, 1'b0, 0, 1'b0);
    do_req(32'h40, 32'h0, 4'h0, 1'b0);
    chk("ehi_ncnt", 32'(ncnt), 32'd1);
    chk("ehi_err", 32'(ack_err), 32'd1);
    chk("ehi_data", ack_rd, 32'h0);

    // low half error
    set_rsp(0, 16'hAAAA, 1'b0, 0, 1'b0);
    set_rsp(1, 16'h9999, 1'b1, 0, 1'b0);
    do_req(32'h50, 32'h0, 4'h0, 1'b0);
    chk("elo_ncnt", 32'(ncnt), 32'd2);
    chk("elo_err", 32'(ack_err), 32'd1);
    chk("elo_data", ack_rd, 32'hAAAA0000);

    // nack on the last cycle before timeout succeeds
    set_rsp(0, 16'h1234, 1'b0, 8, 1'b0);
    set_rsp(1, 16'h5678, 1'b0, 0, 1'b0);
    do_req(32'h60, 32'h0, 4'h0, 1'b0);
    chk("tedge_err", 32'(ack_err), 32'd0);
    chk("tedge_data", ack_rd, 32'h12345678);

    // nack one cycle too late on the high half
    set_rsp(0, 16'h4321, 1'b0, 9, 1'b0);
    set_rsp(1, 16'h0, 1'b0, 0, 1'b0);
    do_req(32'h70, 32'h0, 4'h0, 1'b0);
    chk("thi_ncnt", 32'(ncnt), 32'd1);
    chk("thi_err", 32'(ack_err), 32'd1);
    chk("thi_dly", 32'(ack_cyc - lg_cyc[0]), 32'd10);
    chk("thi_data", ack_rd, 32'h0);
    repeat (3) @(posedge clk);
    #1;

    // low half never answers
    set_rsp(0, 16'hBEEF, 1'b0, 0, 1'b0);
    set_rsp(1, 16'h0, 1'b0, 0, 1'b1);
    do_req(32'h80, 32'h0, 4'h0, 1'b0);
    chk("tlo_ncnt", 32'(ncnt), 32'd2);
    chk("tlo_err", 32'(ack_err), 32'd1);
    chk("tlo_dly", 32'(ack_cyc - lg_cyc[1]), 32'd10);
    chk("tlo_data", ack_rd, 32'hBEEF0000);
    poke_nack("late_nack");
    set_rsp(0, 16'h0102, 1'b0, 0, 1'b0);
    set_rsp(1, 16'h0304, 1'b0, 0, 1'b0);
    do_req(32'h90, 32'h0, 4'h0, 1'b0);
    chk("after_to_err", 32'(ack_err), 32'd0);
    chk("after_to_data", ack_rd, 32'h01020304);

    // reset while waiting on the low half
    set_rsp(0, 16'h5555, 1'b0, 0, 1'b0);
    set_rsp(1, 16'h0, 1'b0, 0, 1'b1);
    ncnt  = 0;
    start = ack_cnt;
    addr  = 32'hA0;
    wr    = 1'b0;
    wstrb = 4'h0;
    req   = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ncnt >= 2) break;
      @(posedge clk);
      #1;
    end
    chk("mrst_ncnt", 32'(ncnt), 32'd2);
    repeat (2) @(posedge clk);
    #1;
    chk("mrst_pre_rd", rdata, 32'h55550000);
    rstn = 1'b0;
    #1;
    chk("mrst_nreq", 32'(nreq), 32'd0);
    chk("mrst_rdata", rdata, 32'h0);
    chk("mrst_naddr", naddr, 32'h0);
    chk("mrst_nwstrb", 32'(nwstrb), 32'h0);
    chk("mrst_ack", 32'(ack), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("mrst_noack", 32'(ack_cnt - start), 32'd0);
    poke_nack("mrst_late_nack");
    set_rsp(0, 16'hC0DE, 1'b0, 1, 1'b0);
    set_rsp(1, 16'hF00D, 1'b0, 0, 1'b0);
    do_req(32'hB0, 32'h0, 4'h0, 1'b0);
    chk("mrst_rd_data", ack_rd, 32'hC0DEF00D);
    chk("mrst_rd_err", 32'(ack_err), 32'd0);

    chk("ack_nreq_both", 32'(both_cnt), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
